// File: rtl/bf_sweep_capture.sv
// ============================================================================
// Module   : bf_sweep_capture
// Summary  : Clocked truth-table sweeper and checker for an N_IN-input boolean
//            function block; drives every input vector, captures the result,
//            compares it against an expected table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_sweep_capture #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp,
    input  logic                 fin,
    output logic [N_IN-1:0]      drv,
    output logic [2**N_IN-1:0]   truthTable,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN-1:0]      first_fail
);

    localparam int               c_TBL_W       = 2**N_IN;
    localparam logic [N_IN-1:0]  c_LAST_IDX    = '1;
    localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [N_IN-1:0]     r_idx;
    logic [3:0]          r_cnt;
    logic [c_TBL_W-1:0]  r_exp;

    logic [c_TBL_W-1:0]  w_finalTable;
    logic [c_TBL_W-1:0]  w_diff;
    logic [N_IN-1:0]     w_firstFail;

    // The verdict is formed on the same edge that captures the last bit, so
    // the table is completed combinationally with the bit being sampled.
    always_comb begin
        w_finalTable        = truthTable;
        w_finalTable[r_idx] = fin;
        w_diff              = w_finalTable ^ r_exp;
        w_firstFail         = '0;
        for (int i = c_TBL_W - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_firstFail = N_IN'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_exp      <= '0;
            drv        <= '0;
            truthTable <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            first_fail <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    drv  <= '0;
                    busy <= 1'b0;
                    if (start) begin
                        r_exp      <= exp;
                        truthTable <= '0;
                        r_idx      <= '0;
                        r_cnt      <= '0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        first_fail <= '0;
                        r_state    <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        truthTable[r_idx] <= fin;
                        r_cnt             <= '0;
                        if (r_idx == c_LAST_IDX) begin
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            pass       <= (w_diff == '0);
                            first_fail <= w_firstFail;
                            drv        <= '0;
                            r_state    <= S_DONE;
                        end else begin
                            r_idx <= r_idx + N_IN'(1);
                            drv   <= r_idx + N_IN'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bf_sweep_capture.sv
// Testbench for bf_sweep_capture: random and directed sweeps checked against a
// truth-table reference model; a second instance covers the SETTLE=1 build.
`timescale 1ns/1ps
`default_nettype none

module tb_bf_sweep_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start1;
    logic [7:0] expv, exp1;
    logic       fin, fin1;
    logic [2:0] drv, drv1;
    logic [7:0] tbl, tbl1;
    logic       busy, done, pass, busy1, done1, pass1;
    logic [2:0] ff, ff1;

    int         mode;
    logic [7:0] fnTbl;
    int         errors = 0;
    int         checks = 0;

    bf_sweep_capture #(.N_IN(3), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .exp(expv), .fin(fin),
        .drv(drv), .truthTable(tbl), .busy(busy), .done(done),
        .pass(pass), .first_fail(ff)
    );

    bf_sweep_capture #(.N_IN(3), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .exp(exp1), .fin(fin1),
        .drv(drv1), .truthTable(tbl1), .busy(busy1), .done(done1),
        .pass(pass1), .first_fail(ff1)
    );

    // Function under test: parity, inA only, or an arbitrary random table.
    always_comb begin
        case (mode)
            0:       fin = drv[0] ^ drv[1] ^ drv[2];
            1:       fin = drv[2];
            default: fin = fnTbl[drv];
        endcase
    end
    assign fin1 = ~drv1[0];

    // ---------------- reference model ----------------
    function automatic logic ref_fn(input int m, input logic [7:0] ft, input int v);
        logic [2:0] b;
        b = 3'(v);
        case (m)
            0:       return b[0] ^ b[1] ^ b[2];
            1:       return b[2];
            default: return ft[v];
        endcase
    endfunction

    function automatic logic [7:0] ref_table(input int m, input logic [7:0] ft);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = ref_fn(m, ft, i);
        return t;
    endfunction

    function automatic logic [2:0] ref_ff(input logic [7:0] t, input logic [7:0] e);
        for (int i = 0; i < 8; i++) if (t[i] != e[i]) return 3'(i);
        return 3'd0;
    endfunction

    // Pulses start, scrambles exp after acceptance, measures done latency.
    task automatic run_sweep(input logic [7:0] e, output int lat, output int nDone);
        expv  = e;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        expv  = ~e;
        lat   = -1;
        nDone = 0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (done) begin
                nDone++;
                if (lat < 0) lat = c;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({drv, tbl, busy, done, pass, ff} !== 17'h0) begin
            errors++;
            $display("FAIL reset_dut: got drv=%h tbl=%h busy=%b done=%b pass=%b ff=%h want all 0",
                     drv, tbl, busy, done, pass, ff);
        end
        checks++;
        if ({drv1, tbl1, busy1, done1, pass1, ff1} !== 17'h0) begin
            errors++;
            $display("FAIL reset_dut1: got drv=%h tbl=%h busy=%b done=%b want all 0",
                     drv1, tbl1, busy1, done1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_parity;
        int stepErr;
        logic [2:0] wantDrv;
        mode    = 0;
        expv    = 8'h96;
        start   = 1'b1;
        stepErr = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            wantDrv = (c < 16) ? 3'(c / 2) : 3'd0;
            checks++;
            if (drv !== wantDrv || done !== (c == 16) || busy !== (c < 16)) begin
                errors++;
                $display("FAIL parity_step c=%0d: got drv=%0d done=%b busy=%b want drv=%0d done=%b busy=%b",
                         c, drv, done, busy, wantDrv, (c == 16), (c < 16));
            end
        end
        checks++;
        if (tbl !== ref_table(0, 8'h0) || tbl !== 8'h96 || pass !== 1'b1 || ff !== 3'd0) begin
            errors++;
            $display("FAIL parity_result: got tbl=%h pass=%b ff=%0d want tbl=96 pass=1 ff=0", tbl, pass, ff);
        end
    endtask

    task automatic test_mismatch;
        int lat, nd;
        logic [7:0] e [2];
        e[0] = 8'h97;
        e[1] = 8'h16;
        mode = 0;
        for (int k = 0; k < 2; k++) begin
            run_sweep(e[k], lat, nd);
            checks++;
            if (tbl !== 8'h96 || pass !== 1'b0 || ff !== ref_ff(8'h96, e[k]) || lat != 16 || nd != 1) begin
                errors++;
                $display("FAIL mismatch exp=%h: got tbl=%h pass=%b ff=%0d lat=%0d nd=%0d want tbl=96 pass=0 ff=%0d lat=16 nd=1",
                         e[k], tbl, pass, ff, lat, nd, ref_ff(8'h96, e[k]));
            end
        end
    endtask

    task automatic test_single_input;
        int lat, nd;
        mode = 1;
        run_sweep(8'hF0, lat, nd);
        checks++;
        if (tbl !== 8'hF0 || pass !== 1'b1 || ff !== 3'd0 || lat != 16) begin
            errors++;
            $display("FAIL single_pass: got tbl=%h pass=%b ff=%0d lat=%0d want F0 1 0 16", tbl, pass, ff, lat);
        end
        run_sweep(8'hCC, lat, nd);
        checks++;
        if (tbl !== 8'hF0 || pass !== 1'b0 || ff !== 3'd2) begin
            errors++;
            $display("FAIL single_fail: got tbl=%h pass=%b ff=%0d want F0 0 2", tbl, pass, ff);
        end
    endtask

    task automatic test_start_ignored;
        int q[$];
        mode  = 0;
        expv  = 8'h96;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (c == 4) start = 1'b1;
            if (c == 5) start = 1'b0;
            if (done) q.push_back(c);
        end
        checks++;
        if (q.size() != 1 || (q.size() > 0 && q[0] != 16) || busy !== 1'b0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: got pulses=%0d first=%0d busy=%b pass=%b want pulses=1 first=16 busy=0 pass=1",
                     q.size(), (q.size() > 0) ? q[0] : -1, busy, pass);
        end
    endtask

    task automatic test_back_to_back;
        int q[$];
        mode  = 0;
        expv  = 8'h96;
        start = 1'b1;
        for (int c = 0; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) q.push_back(c);
        end
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses want 3", q.size());
        end else begin
            checks++;
            if (q[0] != 16 || q[1] - q[0] != 18 || q[2] - q[1] != 18) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d,%0d,%0d want 16,34,52", q[0], q[1], q[2]);
            end
        end
        checks++;
        if (busy !== 1'b0 || tbl !== 8'h96) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b tbl=%h want 0 96", busy, tbl);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int nd, lat, nd2;
        mode  = 0;
        expv  = 8'h96;
        start = 1'b1;
        nd    = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 6) rst = 1'b1;
            if (c == 7) begin
                rst = 1'b0;
                checks++;
                if (drv !== 3'd0 || busy !== 1'b0 || tbl !== 8'h00 || pass !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid: got drv=%0d busy=%b tbl=%h pass=%b want 0 0 00 0",
                             drv, busy, tbl, pass);
                end
            end
            if (done) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", nd);
        end
        mode  = 2;
        fnTbl = 8'($urandom);
        run_sweep(fnTbl, lat, nd2);
        checks++;
        if (tbl !== ref_table(2, fnTbl) || pass !== 1'b1 || lat != 16 || nd2 != 1) begin
            errors++;
            $display("FAIL reset_resweep: got tbl=%h pass=%b lat=%0d nd=%0d want tbl=%h pass=1 lat=16 nd=1",
                     tbl, pass, lat, nd2, ref_table(2, fnTbl));
        end
    endtask

    task automatic test_random;
        int lat, nd, sel;
        logic [7:0] e, t;
        mode = 2;
        for (int k = 0; k < 8; k++) begin
            fnTbl = 8'($urandom);
            sel   = $urandom_range(0, 2);
            t     = ref_table(2, fnTbl);
            if (sel == 0)      e = t;
            else if (sel == 1) e = t ^ (8'h01 << $urandom_range(0, 7));
            else               e = 8'($urandom);
            run_sweep(e, lat, nd);
            checks++;
            if (tbl !== t || pass !== (t == e) || ff !== ref_ff(t, e) || lat != 16 || nd != 1) begin
                errors++;
                $display("FAIL random k=%0d fn=%h exp=%h: got tbl=%h pass=%b ff=%0d lat=%0d nd=%0d want tbl=%h pass=%b ff=%0d lat=16 nd=1",
                         k, fnTbl, e, tbl, pass, ff, lat, nd, t, (t == e), ref_ff(t, e));
            end
        end
    endtask

    task automatic test_settle1;
        logic [2:0] wantDrv;
        exp1   = 8'h55;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            wantDrv = (c < 8) ? 3'(c) : 3'd0;
            checks++;
            if (drv1 !== wantDrv || done1 !== (c == 8)) begin
                errors++;
                $display("FAIL settle1_step c=%0d: got drv=%0d done=%b want drv=%0d done=%b",
                         c, drv1, done1, wantDrv, (c == 8));
            end
        end
        checks++;
        if (tbl1 !== 8'h55 || pass1 !== 1'b1 || ff1 !== 3'd0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL settle1_result: got tbl=%h pass=%b ff=%0d busy=%b want 55 1 0 0",
                     tbl1, pass1, ff1, busy1);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        expv   = 8'h00;
        exp1   = 8'h00;
        mode   = 0;
        fnTbl  = 8'h00;
        test_reset();
        test_parity();
        test_mismatch();
        test_single_input();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        test_settle1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bf_sweep_capture.md
Name: bf_sweep_capture

Overview:
- Synthesizable truth-table sweeper for a 3-input combinational boolean-function block of the bf_1_b family. Replaces the free-running toggle stimulus with a clocked, self-checking stage.
- Drives all 2^N_IN input combinations into the function under test (upstream role) and captures its single-bit output into a truth-table register (downstream role).
- Compares the captured table against an expected table and reports pass/fail with a one-cycle done pulse.

Parameters:
- N_IN, 3, number of function inputs; drv width; table width = 2^N_IN.
- SETTLE, 2, cycles each input vector is held before fin is sampled; legal range 1..15. SETTLE=0 is illegal.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- exp  input  2^N_IN  expected truth table; bit i = expected output for input vector i. Sampled at the start-accept edge.
- fin  input  1  output of the function under test (combinational from drv).
- drv  output  N_IN  input vector to the function under test. drv[N_IN-1] = inA (slowest-changing bit); drv[0] = inC (fastest-changing bit).
- table  output  2^N_IN  captured truth table; bit i = fin sampled while drv==i.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  table==exp for the last completed sweep.
- first_fail  output  N_IN  lowest index i with table[i]!=exp[i]; 0 when pass=1.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; drv=0, table=0, busy=0, done=0, pass=0, first_fail=0; index and settle counter cleared; latched exp cleared.
- Reset is honoured in every state. A reset mid-sweep aborts the sweep with no done pulse and no partial result.
- States: IDLE, SWEEP, DONE. All outputs are registered.
- IDLE:
  - drv=0, busy=0.
  - start=1 at an edge: latch exp, clear table, set idx=0, set cnt=0, set busy=1, go to SWEEP.
  - pass and first_fail are cleared at the start-accept edge.
- SWEEP:
  - drv=idx throughout.
  - cnt increments each edge.
  - At the edge where cnt==SETTLE-1: table[idx]<=fin and cnt<=0.
    - If idx==2^N_IN-1, go to DONE.
    - Otherwise idx<=idx+1, so drv advances on the same edge.
  - Each vector is therefore held exactly SETTLE cycles, and fin is sampled on the final edge of that window.
- Transition SWEEP to DONE, on the same edge:
  - busy<=0, done<=1.
  - pass<=(final table==latched exp).
  - first_fail<=lowest mismatching index, or 0 if there is none.
  - drv<=0.
- DONE: held for exactly one cycle. done returns to 0 at the next edge; go to IDLE.
- start is ignored in SWEEP and DONE; there is no queuing.
- With start held high continuously, sweeps run back-to-back with period 2^N_IN*SETTLE+2 cycles.
- table, pass and first_fail hold their values from DONE until the next accepted start.
- Timing, with start accepted at edge E0: sample edges are E(k*SETTLE) for k=1..2^N_IN. done is high during the cycle after edge E(2^N_IN*SETTLE). For the defaults, done is high between E16 and E17.
- Index counter is N_IN bits wide and never wraps during a sweep; the terminal index is detected explicitly.
- Settle counter is 4 bits wide.

Test Plan:
- Parity: fin=^drv, exp=8'h96, SETTLE=2, pulse start for 1 cycle.
  - Expect drv steps 0..7, each value held 2 cycles.
  - Expect table=8'h96, pass=1, first_fail=0, done high only between E16 and E17, busy low afterwards.
- Mismatch: fin=^drv, exp=8'h97.
  - Expect table=8'h96, pass=0, first_fail=0.
  - Repeat with exp=8'h16: expect first_fail=7.
- Single input: fin=drv[2] (inA).
  - Expect table=8'hF0.
  - With exp=8'hF0 expect pass=1. With exp=8'hCC expect pass=0 and first_fail=2.
- Start handling:
  - Pulse start again at E5 of a sweep: ignored, only one done pulse, timing unchanged.
  - Hold start high continuously: done pulses spaced 18 cycles apart.
- Reset mid-sweep: assert rst for one cycle at E7.
  - Next cycle: drv=0, busy=0, table=0, pass=0, and no done pulse follows.
  - A subsequent start runs a full, correct sweep.
- SETTLE=1 build, fin=~drv[0]:
  - Expect table=8'h55 and done high between E8 and E9.
  - Expect drv to change every cycle.
